display_digit_buffer: RTL and testbench
=======================================

// Module: display_digit_buffer
// PURPOSE
//   Downstream stage of the calculator core. Captures the (data, pos) digit writes and the
//   status code produced by the core into an 8-digit store, and decodes each digit to
//   seven-segment bytes d0..d7 ({dp,g,f,e,d,c,b,a}). Adds blink-on-error and a busy indicator.
//   Outputs feed the board display pins directly.
// PARAMETERS
//   BLINK_DIV       25_000_000  clock cycles per blink half-period (0.5 s @ 50 MHz); >= 2
//   SEG_ACTIVE_LOW  1           1: segment lit = 0 (outputs inverted); 0: lit = 1
// PORTS
//   clock   in   1  system clock, all state on rising edge
//   reset   in   1  asynchronous, active-high; clears digit store, blink state, outputs
//   wr      in   1  write strobe; data is written to digit[pos] on the edge where wr=1
//   data    in   4  digit code (see decode table)
//   pos     in   4  digit index: 0..7 = d0..d7 (d0 rightmost); 15 = clear-all; 8..14 ignored
//   status  in   2  00 ready, 01 busy, 10 result, 11 error
//   d0..d7  out  8  each is {dp,g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW
// BEHAVIOUR
//   Store: 8 entries of {blank, code[3:0]}. Reset -> all blank=1, code=0.
//   - wr=1 & pos<=7  : digit[pos] <= {0,data}. Other entries unchanged.
//   - wr=1 & pos==15 : all entries -> blank. data ignored.
//   - wr=1 & pos 8..14 or wr=0: store unchanged.
//   Decode (active-high, before polarity): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F
//     9=6F, 10='-'=40, 11='E'=79, 12='r'=50, 13..15 = 00. Blank entry = 00.
//   Outputs are registered: a write on edge N appears on dN..d7 after edge N+1 (1-cycle
//     latency from store to pins; store itself updates on edge N).
//   Blink: counter cnt and phase bit. Active only while status==11:
//     cnt increments each cycle; when cnt==BLINK_DIV-1, cnt<=0 and phase toggles.
//     While status!=11: cnt<=0, phase<=0 (synchronous, next edge).
//     phase=1 -> all eight digits output as blank (dp included). phase=0 -> normal.
//     So entering error shows digits for exactly BLINK_DIV cycles, then blank BLINK_DIV, ...
//   dp: dp of d0 lit iff status==01 (busy); all other dp bits always off. Busy dp is not
//     blanked (status 01 and 11 are exclusive).
//   status==00/10: plain display, no dp, no blink.
//   Simultaneous: wr and status change on the same edge both take effect that edge;
//     clear-all during blink-off phase still blanks the store (visible once phase=0).
//   Reset (any time, incl. mid-blink): store blank, cnt=0, phase=0, every dN = all segments
//     off (8'hFF when SEG_ACTIVE_LOW=1, 8'h00 otherwise), asynchronously.
//   Width: cnt is $clog2(BLINK_DIV) bits; no overflow since it wraps at BLINK_DIV-1.
// TESTING (BLINK_DIV=4, SEG_ACTIVE_LOW=1 unless noted)
//   1 Reset asserted mid-run -> d0..d7 = FF immediately; after release with wr=0 stays FF.
//   2 wr=1,pos=0,data=7 then pos=7,data=0 -> d0=F8 (~07), d7=C0 (~3F) one cycle after each;
//     d1..d6 remain FF.
//   3 wr=1,pos=9,data=3 -> no output change; then pos=15 -> all dN=FF next-next cycle.
//   4 Store "E","r","r" in d2..d0 (11,12,12), status=11 for 16 cycles -> digits visible 4
//     cycles, FF for 4, repeating; drop status to 10 mid-blank -> digits visible next cycle.
//   5 status=01 with d0=5 -> d0=12 (~(80|6D)); status=10 -> d0=92.
//   6 SEG_ACTIVE_LOW=0: write 8 to pos 3 -> d3=7F; reset -> all 00.

Source files
------------

// File: rtl/display_digit_buffer.sv
// display_digit_buffer
//   Eight-digit store fed by the calculator core. Each digit is written through (wr, pos,
//   data) and decoded to a seven-segment byte {dp,g,f,e,d,c,b,a}. While the core reports
//   an error, the whole display blinks with a half-period of BLINK_DIV cycles. While the
//   core is busy, the decimal point of d0 is lit. Output bytes are registered, so a change
//   in the store reaches the pins one edge after the store itself changes.
module display_digit_buffer #(
  parameter int BLINK_DIV      = 25_000_000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       wr,
  input  logic [3:0] data,
  input  logic [3:0] pos,
  input  logic [1:0] status,
  output logic [7:0] d0,
  output logic [7:0] d1,
  output logic [7:0] d2,
  output logic [7:0] d3,
  output logic [7:0] d4,
  output logic [7:0] d5,
  output logic [7:0] d6,
  output logic [7:0] d7
);

  localparam int         CNT_W    = $clog2(BLINK_DIV);
  localparam logic [7:0] SEG_OFF  = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [4:0] BLANK_E  = 5'b1_0000;
  localparam logic [1:0] ST_BUSY  = 2'b01;
  localparam logic [1:0] ST_ERROR = 2'b11;

  // Store entry: bit 4 = blank, bits 3:0 = digit code.
  logic [7:0][4:0] store_q, store_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;
  logic [7:0][7:0]  seg_q, seg_d;

  // Active-high segment pattern {g,f,e,d,c,b,a} for one digit code.
  function automatic logic [6:0] seg_decode(input logic [3:0] code);
    logic [6:0] s;
    case (code)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      4'd10:   s = 7'h40;   // '-'
      4'd11:   s = 7'h79;   // 'E'
      4'd12:   s = 7'h50;   // 'r'
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // Digit store update: single-digit write, clear-all on pos 15, positions 8..14 ignored.
  always_comb begin
    store_d = store_q;
    if (wr) begin
      if (!pos[3]) begin
        store_d[pos[2:0]] = {1'b0, data};
      end else if (pos == 4'hF) begin
        for (int i = 0; i < 8; i++) store_d[i] = BLANK_E;
      end
    end
  end

  // Blink timer: runs only while in error, otherwise held at the visible phase.
  always_comb begin
    cnt_d   = '0;
    phase_d = 1'b0;
    if (status == ST_ERROR) begin
      if (cnt_q == CNT_W'(BLINK_DIV - 1)) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d   = cnt_q + CNT_W'(1);
        phase_d = phase_q;
      end
    end
  end

  // Next output bytes from the current store; blink-off hides digits, busy dp is never hidden.
  always_comb begin
    seg_d = '0;
    for (int i = 0; i < 8; i++) begin
      logic [7:0] lit;
      lit = 8'h00;
      if (!phase_q && !store_q[i][4]) lit[6:0] = seg_decode(store_q[i][3:0]);
      if (i == 0 && status == ST_BUSY) lit[7] = 1'b1;
      seg_d[i] = SEG_ACTIVE_LOW ? ~lit : lit;
    end
  end

  // State and output registers; reset blanks everything immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      store_q <= {8{BLANK_E}};
      cnt_q   <= '0;
      phase_q <= 1'b0;
      seg_q   <= {8{SEG_OFF}};
    end else begin
      store_q <= store_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      seg_q   <= seg_d;
    end
  end

  assign d0 = seg_q[0];
  assign d1 = seg_q[1];
  assign d2 = seg_q[2];
  assign d3 = seg_q[3];
  assign d4 = seg_q[4];
  assign d5 = seg_q[5];
  assign d6 = seg_q[6];
  assign d7 = seg_q[7];

endmodule

// File: tb/tb_display_digit_buffer.sv
// Testbench for display_digit_buffer: two instances (active-low and active-high segments)
// share the same stimulus; a reference model predicts each registered output and a
// monitor compares the pins after every rising edge.
module tb_display_digit_buffer;

  localparam int BD = 4;

  logic       clock  = 1'b0;
  logic       reset  = 1'b1;
  logic       wr     = 1'b0;
  logic [3:0] data   = 4'd0;
  logic [3:0] pos    = 4'd0;
  logic [1:0] status = 2'd0;

  logic [7:0] a0, a1, a2, a3, a4, a5, a6, a7;
  logic [7:0] b0, b1, b2, b3, b4, b5, b6, b7;

  int total = 0;
  int bad   = 0;

  display_digit_buffer #(.BLINK_DIV(BD), .SEG_ACTIVE_LOW(1'b1)) dut_lo (
    .clock(clock), .reset(reset), .wr(wr), .data(data), .pos(pos), .status(status),
    .d0(a0), .d1(a1), .d2(a2), .d3(a3), .d4(a4), .d5(a5), .d6(a6), .d7(a7)
  );

  display_digit_buffer #(.BLINK_DIV(BD), .SEG_ACTIVE_LOW(1'b0)) dut_hi (
    .clock(clock), .reset(reset), .wr(wr), .data(data), .pos(pos), .status(status),
    .d0(b0), .d1(b1), .d2(b2), .d3(b3), .d4(b4), .d5(b5), .d6(b6), .d7(b7)
  );

  always #5 clock = ~clock;

  // Reference model: digit contents, blank flags, and the length of the current error run.
  int         m_code  [8];
  bit         m_blank [8];
  int         m_run;
  logic [7:0] tbl [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                           8'h7F, 8'h6F, 8'h40, 8'h79, 8'h50, 8'h00, 8'h00, 8'h00};

  // Scoreboard of expected active-high images {d7,...,d0} for the next rising edge.
  logic [63:0] sbq [$];

  function automatic logic [63:0] predict_lit(input logic [1:0] st);
    logic [63:0] r;
    bit          off_phase;
    off_phase = ((m_run / BD) % 2) == 1;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      logic [7:0] lit;
      lit = m_blank[i] ? 8'h00 : tbl[m_code[i]];
      if (off_phase) lit = 8'h00;
      if (i == 0 && st == 2'b01) lit = lit | 8'h80;
      r[i*8 +: 8] = lit;
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_code[i]  = 0;
      m_blank[i] = 1'b1;
    end
    m_run = 0;
  endtask

  // Drive one cycle of inputs at the falling edge and record the expected pins.
  task automatic step(input bit r_i, input bit w_i, input logic [3:0] p_i,
                      input logic [3:0] dt_i, input logic [1:0] st_i);
    @(negedge clock);
    reset  = r_i;
    wr     = w_i;
    pos    = p_i;
    data   = dt_i;
    status = st_i;
    if (r_i) begin
      model_reset();
      sbq.push_back(64'h0);
      #1;
      total++;
      if ({a7, a6, a5, a4, a3, a2, a1, a0} !== {64{1'b1}}) begin
        bad++;
        $display("FAIL reset_async_lo t=%0t got=%h want=%h", $time,
                 {a7, a6, a5, a4, a3, a2, a1, a0}, {64{1'b1}});
      end
      total++;
      if ({b7, b6, b5, b4, b3, b2, b1, b0} !== 64'h0) begin
        bad++;
        $display("FAIL reset_async_hi t=%0t got=%h want=%h", $time,
                 {b7, b6, b5, b4, b3, b2, b1, b0}, 64'h0);
      end
    end else begin
      sbq.push_back(predict_lit(st_i));
      if (w_i) begin
        if (p_i <= 4'd7) begin
          m_code[p_i]  = int'(dt_i);
          m_blank[p_i] = 1'b0;
        end else if (p_i == 4'd15) begin
          for (int i = 0; i < 8; i++) m_blank[i] = 1'b1;
        end
      end
      m_run = (st_i == 2'b11) ? m_run + 1 : 0;
    end
  endtask

  task automatic idle(input int n, input logic [1:0] st_i);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 4'd0, 4'd0, st_i);
  endtask

  // Monitor: after each rising edge, compare both instances with the oldest expectation.
  always @(posedge clock) begin
    logic [63:0] e;
    #1;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      total++;
      if ({a7, a6, a5, a4, a3, a2, a1, a0} !== ~e) begin
        bad++;
        $display("FAIL segs_lo t=%0t got=%h want=%h", $time,
                 {a7, a6, a5, a4, a3, a2, a1, a0}, ~e);
      end
      total++;
      if ({b7, b6, b5, b4, b3, b2, b1, b0} !== e) begin
        bad++;
        $display("FAIL segs_hi t=%0t got=%h want=%h", $time,
                 {b7, b6, b5, b4, b3, b2, b1, b0}, e);
      end
    end
  end

  initial begin
    logic [1:0] st;
    model_reset();

    // Power-on reset, then release with nothing written.
    step(1'b1, 1'b0, 4'd0, 4'd0, 2'b00);
    step(1'b1, 1'b0, 4'd0, 4'd0, 2'b00);
    idle(2, 2'b00);

    // Single-digit writes at both ends.
    step(1'b0, 1'b1, 4'd0, 4'd7, 2'b00);
    step(1'b0, 1'b1, 4'd7, 4'd0, 2'b00);
    idle(2, 2'b00);

    // Ignored position, then clear-all.
    step(1'b0, 1'b1, 4'd9, 4'd3, 2'b00);
    idle(1, 2'b00);
    step(1'b0, 1'b1, 4'd15, 4'd5, 2'b00);
    idle(2, 2'b00);

    // "Err" and blinking, leaving error in the blank half.
    step(1'b0, 1'b1, 4'd2, 4'd11, 2'b00);
    step(1'b0, 1'b1, 4'd1, 4'd12, 2'b00);
    step(1'b0, 1'b1, 4'd0, 4'd12, 2'b00);
    idle(22, 2'b11);
    idle(3, 2'b10);

    // Busy decimal point on d0, then result display.
    step(1'b0, 1'b1, 4'd0, 4'd5, 2'b01);
    idle(2, 2'b01);
    idle(2, 2'b10);

    // Write 8 to d3, clear-all during blink-off, then reset mid-blink.
    step(1'b0, 1'b1, 4'd3, 4'd8, 2'b00);
    idle(5, 2'b11);
    step(1'b0, 1'b1, 4'd15, 4'd0, 2'b11);
    idle(4, 2'b11);
    step(1'b0, 1'b1, 4'd4, 4'd9, 2'b11);
    idle(2, 2'b11);
    step(1'b1, 1'b0, 4'd0, 4'd0, 2'b11);
    idle(2, 2'b00);

    // Randomized traffic; status is sticky so error runs span several blink periods.
    st = 2'b00;
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 7) == 0) st = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 99) == 0)
        step(1'b1, 1'b0, 4'd0, 4'd0, st);
      else
        step(1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
             4'($urandom_range(0, 15)), st);
    end
    idle(2, 2'b00);

    repeat (2) @(posedge clock);
    #2;
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d want=0", sbq.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
